// File: rtl/raster_fb_writer.sv
// Framebuffer write stage: clips raster pixels, packs them to RGB565 and buffers them
// in a small FIFO. The FIFO drains to a valid/ready memory port through one output register.
module raster_fb_writer #(
    parameter int unsigned FB_W              = 320,
    parameter int unsigned FB_H              = 240,
    parameter int unsigned ADDR_W            = 17,
    parameter int unsigned FIFO_DEPTH_LOG2   = 4,
    parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_write_pixel,
    input  logic [15:0]       i_x,
    input  logic [15:0]       i_y,
    input  logic [7:0]        i_color_r,
    input  logic [7:0]        i_color_g,
    input  logic [7:0]        i_color_b,
    input  logic [ADDR_W-1:0] i_fb_base,
    input  logic              i_clear_status,
    output logic              o_mem_valid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_data,
    input  logic              i_mem_ready,
    output logic              o_almost_full,
    output logic              o_idle,
    output logic              o_overflow,
    output logic [15:0]       o_clip_count,
    output logic [31:0]       o_write_count
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;

    typedef struct packed {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [15:0] color;
    } pixel_t;

    pixel_t            fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              in_range;
    logic              push_req;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push;
    logic              handshake;
    logic              overflow_event;
    logic              clip_event;
    pixel_t            push_entry;
    pixel_t            head;
    logic [ADDR_W-1:0] head_addr;
    logic              unused_color_bits;

    // Clip test: a negative coordinate has its sign bit set, everything else is compared unsigned.
    always_comb begin
        in_range = !i_x[15] && (i_x < 16'(FB_W)) && !i_y[15] && (i_y < 16'(FB_H));
        push_entry.x     = i_x[8:0];
        push_entry.y     = i_y[7:0];
        push_entry.color = {i_color_r[7:3], i_color_g[7:2], i_color_b[7:3]};
    end

    assign unused_color_bits = ^{i_color_r[2:0], i_color_g[1:0], i_color_b[2:0]};

    always_comb begin
        fifo_empty     = (count == '0);
        fifo_full      = (count == CNT_W'(DEPTH));
        handshake      = o_mem_valid && i_mem_ready;
        pop            = !fifo_empty && (!o_mem_valid || i_mem_ready);
        push_req       = i_write_pixel && in_range;
        // A full FIFO still takes a pixel when the head leaves in the same cycle.
        push           = push_req && (!fifo_full || pop);
        overflow_event = push_req && fifo_full && !pop;
        clip_event     = i_write_pixel && !in_range;
        head           = fifo_mem[rd_ptr];
        head_addr      = i_fb_base + ADDR_W'(head.y) * ADDR_W'(FB_W) + ADDR_W'(head.x);
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Output register: reloads only when empty or the current request is accepted.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_mem_valid <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_data  <= '0;
        end else if (pop) begin
            o_mem_valid <= 1'b1;
            o_mem_addr  <= head_addr;
            o_mem_data  <= head.color;
        end else if (handshake) begin
            o_mem_valid <= 1'b0;
        end
    end

    // Status: clear takes priority over any event on the same edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_overflow    <= 1'b0;
            o_clip_count  <= '0;
            o_write_count <= '0;
        end else if (i_clear_status) begin
            o_overflow    <= 1'b0;
            o_clip_count  <= '0;
            o_write_count <= '0;
        end else begin
            if (overflow_event) begin
                o_overflow <= 1'b1;
            end
            if (clip_event && (o_clip_count != 16'hFFFF)) begin
                o_clip_count <= o_clip_count + 16'd1;
            end
            if (handshake) begin
                o_write_count <= o_write_count + 32'd1;
            end
        end
    end

    assign o_almost_full = (count >= CNT_W'(ALMOST_FULL_LEVEL));
    assign o_idle        = fifo_empty && !o_mem_valid;

endmodule

// File: tb/tb_raster_fb_writer.sv
// Bench for raster_fb_writer: vector table, directed corner sequences and random traffic,
// all checked every cycle against a queue-based reference model.
module tb_raster_fb_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wp = 1'b0;
    logic [15:0] ix = '0;
    logic [15:0] iy = '0;
    logic [7:0]  cr = '0;
    logic [7:0]  cg = '0;
    logic [7:0]  cb = '0;
    logic [16:0] fb_base = '0;
    logic        clr = 1'b0;
    logic        ready = 1'b1;
    logic        mem_valid;
    logic [16:0] mem_addr;
    logic [15:0] mem_data;
    logic        almost_full;
    logic        idle;
    logic        overflow;
    logic [15:0] clip_count;
    logic [31:0] write_count;

    always #5 clk = ~clk;

    raster_fb_writer dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_write_pixel(wp), .i_x(ix), .i_y(iy),
        .i_color_r(cr), .i_color_g(cg), .i_color_b(cb), .i_fb_base(fb_base),
        .i_clear_status(clr), .o_mem_valid(mem_valid), .o_mem_addr(mem_addr),
        .o_mem_data(mem_data), .i_mem_ready(ready), .o_almost_full(almost_full),
        .o_idle(idle), .o_overflow(overflow), .o_clip_count(clip_count),
        .o_write_count(write_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending pixels as a queue, one output slot, plain status values.
    typedef struct { int x; int y; logic [15:0] c; } mpix_t;
    mpix_t       pend[$];
    bit          m_valid = 0;
    int          m_addr = 0;
    logic [15:0] m_data = '0;
    bit          m_ovf = 0;
    int          m_clip = 0;
    logic [31:0] m_wc = '0;

    always @(posedge clk or negedge rst_n) begin
        int sx, sy;
        bit hs, pop, full, inr;
        mpix_t h;
        if (!rst_n) begin
            pend.delete();
            m_valid = 0; m_addr = 0; m_data = '0;
            m_ovf = 0; m_clip = 0; m_wc = '0;
        end else begin
            sx   = $signed(ix);
            sy   = $signed(iy);
            hs   = m_valid && ready;
            pop  = (!m_valid || ready) && (pend.size() > 0);
            full = (pend.size() >= 16);
            inr  = wp && sx >= 0 && sx < 320 && sy >= 0 && sy < 240;
            if (pop) begin
                h = pend.pop_front();
                m_valid = 1;
                m_addr  = (int'(fb_base) + h.y * 320 + h.x) % 131072;
                m_data  = h.c;
            end else if (hs) begin
                m_valid = 0;
            end
            if (inr && (!full || pop)) pend.push_back('{sx, sy, {cr[7:3], cg[7:2], cb[7:3]}});
            if (clr) begin
                m_ovf = 0; m_clip = 0; m_wc = '0;
            end else begin
                if (inr && full && !pop) m_ovf = 1;
                if (wp && !inr && m_clip < 65535) m_clip++;
                if (hs) m_wc++;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_valid", mem_valid, m_valid);
        if (m_valid) begin
            chk("m_addr", mem_addr, m_addr);
            chk("m_data", mem_data, m_data);
        end
        chk("m_almost_full", almost_full, pend.size() >= 12);
        chk("m_idle", idle, pend.size() == 0 && !m_valid);
        chk("m_overflow", overflow, m_ovf);
        chk("m_clip", clip_count, m_clip);
        chk("m_wcount", write_count, m_wc);
    end

    task automatic pix(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b);
        wp = 1'b1; ix = 16'(x); iy = 16'(y); cr = r; cg = g; cb = b;
        @(negedge clk);
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && !idle; i++) @(negedge clk);
        chk("drain_timeout", idle, 1);
    endtask

    typedef struct { int x; int y; logic [7:0] r; logic [7:0] g; logic [7:0] b;
                     bit ev; int ea; logic [15:0] ed; } vec_t;
    vec_t vt[8];

    initial begin
        vt[0] = '{0,      0,   8'h12, 8'h34, 8'h56, 1, 0,     16'h11AA};
        vt[1] = '{319,    0,   8'hFF, 8'hFF, 8'hFF, 1, 319,   16'hFFFF};
        vt[2] = '{0,      239, 8'h00, 8'h00, 8'hFF, 1, 76480, 16'h001F};
        vt[3] = '{320,    239, 8'hFF, 8'h00, 8'h00, 0, 0,     16'h0000};
        vt[4] = '{-32768, 5,   8'hFF, 8'h00, 8'h00, 0, 0,     16'h0000};
        vt[5] = '{100,    100, 8'h80, 8'h40, 8'h20, 1, 32100, 16'h8204};
        vt[6] = '{0,      -1,  8'hFF, 8'hFF, 8'h00, 0, 0,     16'h0000};
        vt[7] = '{5,      240, 8'hFF, 8'hFF, 8'h00, 0, 0,     16'h0000};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", mem_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_idle", idle, 1);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_clip", clip_count, 0);
        chk("rst_wc", write_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pixel latency and packing
        pix(5, 2, 8'hFF, 8'h80, 8'h08);
        wp = 1'b0;
        chk("sp_not_bypassed", mem_valid, 0);
        @(negedge clk);
        chk("sp_valid", mem_valid, 1);
        chk("sp_addr", mem_addr, 645);
        chk("sp_data", mem_data, 16'hFC01);
        @(negedge clk);
        chk("sp_valid_one_cycle", mem_valid, 0);
        chk("sp_wc", write_count, 1);
        chk("sp_idle", idle, 1);

        clear_pulse();
        foreach (vt[i]) begin
            pix(vt[i].x, vt[i].y, vt[i].r, vt[i].g, vt[i].b);
            wp = 1'b0;
            @(negedge clk);
            chk("vec_valid", mem_valid, vt[i].ev);
            if (vt[i].ev) begin
                chk("vec_addr", mem_addr, vt[i].ea);
                chk("vec_data", mem_data, vt[i].ed);
            end
            repeat (2) @(negedge clk);
        end
        chk("vec_clip", clip_count, 4);
        chk("vec_wc", write_count, 4);

        // Clipping boundaries
        clear_pulse();
        pix(320, 0, 8'h00, 8'hFF, 8'h00);
        pix(0, 240, 8'h00, 8'hFF, 8'h00);
        pix(-1, 10, 8'h00, 8'hFF, 8'h00);
        pix(319, 239, 8'h00, 8'hFF, 8'h00);
        wp = 1'b0;
        @(negedge clk);
        chk("clip_valid", mem_valid, 1);
        chk("clip_addr", mem_addr, 76799);
        chk("clip_data", mem_data, 16'h07E0);
        wait_idle();
        chk("clip_count", clip_count, 3);
        chk("clip_wc", write_count, 1);

        // Backpressure: 16 pixels held, then drained one per cycle
        clear_pulse();
        ready = 1'b0;
        for (int i = 0; i < 16; i++) pix(i, 1, 8'(i * 16), 8'h00, 8'h00);
        wp = 1'b0;
        chk("bp_af", almost_full, 1);
        chk("bp_valid", mem_valid, 1);
        chk("bp_hold_addr", mem_addr, 320);
        ready = 1'b1;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            chk("bp_burst_valid", mem_valid, 1);
            chk("bp_burst_addr", mem_addr, 320 + k);
        end
        @(negedge clk);
        chk("bp_end_valid", mem_valid, 0);
        chk("bp_wc", write_count, 16);
        chk("bp_ovf", overflow, 0);

        // Overflow: 20 pixels against a stalled port
        clear_pulse();
        ready = 1'b0;
        for (int i = 0; i < 20; i++) pix(i, 3, 8'hAA, 8'h55, 8'h11);
        wp = 1'b0;
        chk("ov_flag", overflow, 1);
        chk("ov_af", almost_full, 1);
        ready = 1'b1;
        wait_idle();
        chk("ov_wc", write_count, 17);
        clear_pulse();
        chk("clr_ovf", overflow, 0);
        chk("clr_clip", clip_count, 0);
        chk("clr_wc", write_count, 0);

        // Full FIFO with a pop and a push on the same edge
        ready = 1'b0;
        for (int i = 0; i < 17; i++) pix(i, 4, 8'h10, 8'h20, 8'h30);
        ready = 1'b1;
        pix(200, 4, 8'hF0, 8'h0F, 8'hAA);
        wp = 1'b0;
        chk("fp_ovf", overflow, 0);
        wait_idle();
        chk("fp_wc", write_count, 18);

        // Base wrap
        fb_base = 17'h1FFFF;
        pix(1, 0, 8'h00, 8'h00, 8'h00);
        wp = 1'b0;
        @(negedge clk);
        chk("wrap_valid", mem_valid, 1);
        chk("wrap_addr", mem_addr, 0);
        wait_idle();

        // Asynchronous reset while a request is pending
        ready = 1'b0;
        pix(7, 7, 8'h11, 8'h22, 8'h33);
        wp = 1'b0;
        @(negedge clk);
        chk("ar_pre_valid", mem_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", mem_valid, 0);
        chk("ar_wc", write_count, 0);
        chk("ar_clip", clip_count, 0);
        chk("ar_ovf", overflow, 0);
        chk("ar_idle", idle, 1);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;

        // Random traffic: light then heavy backpressure, occasional status clears
        fb_base = 17'($urandom_range(0, 131071));
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            wp    = 1'($urandom % 2);
            ix    = 16'($urandom_range(0, 340)) - 16'd10;
            iy    = 16'($urandom_range(0, 260)) - 16'd10;
            cr    = 8'($urandom);
            cg    = 8'($urandom);
            cb    = 8'($urandom);
            ready = (c < 1500) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
            clr   = ($urandom % 64 == 0);
            @(negedge clk);
        end
        wp = 1'b0;
        clr = 1'b0;
        ready = 1'b1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/raster_fb_writer.md
Name: raster_fb_writer

Overview:
- Downstream stage of the triangle raster engine: consumes its pixel stream (write strobe, signed x/y, 8-bit RGB), clips it to the framebuffer, packs it to RGB565 and issues framebuffer writes over a valid/ready memory port.
- The raster engine cannot stall, so this block provides a FIFO buffer and drains it to memory at whatever rate the memory accepts.
- Drops are reported through sticky status flags and counters.

Parameters:
- FB_W, 320, framebuffer width in pixels.
- FB_H, 240, framebuffer height in pixels.
- ADDR_W, 17, pixel-word address width.
- FIFO_DEPTH_LOG2, 4, log2 of FIFO entries (16).
- ALMOST_FULL_LEVEL, 12, occupancy at or above which o_almost_full is high.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_write_pixel  in  1  pixel strobe from raster engine
- i_x  in  16  signed pixel x
- i_y  in  16  signed pixel y
- i_color_r  in  8  red
- i_color_g  in  8  green
- i_color_b  in  8  blue
- i_fb_base  in  ADDR_W  framebuffer base word address; quasi-static
- i_clear_status  in  1  clears sticky flags and counters
- o_mem_valid  out  1  write request valid
- o_mem_addr  out  ADDR_W  word address
- o_mem_data  out  16  RGB565 pixel
- i_mem_ready  in  1  memory accepts request
- o_almost_full  out  1  occupancy >= ALMOST_FULL_LEVEL, for upstream draw gating
- o_idle  out  1  FIFO empty and o_mem_valid low
- o_overflow  out  1  sticky: a pixel was dropped because the FIFO was full
- o_clip_count  out  16  pixels discarded by clipping; saturating
- o_write_count  out  32  completed memory writes; wraps

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - Reset values: o_mem_valid=0, o_mem_addr=0, o_mem_data=0, o_overflow=0, o_clip_count=0, o_write_count=0, FIFO empty, o_idle=1, o_almost_full=0.
  - Assertion mid-transfer abandons the pending request immediately; the memory side must tolerate valid dropping.
- Clip stage (at the i_write_pixel edge):
  - A pixel is in range iff 0 <= x < FB_W and 0 <= y < FB_H, signed compare.
  - x == FB_W or y == FB_H is out of range. The engine's bounding box is inclusive at 320/240, so those pixels must be dropped.
  - Out-of-range pixels are not pushed; o_clip_count increments, saturating at 16'hFFFF.
- FIFO push/pop:
  - An in-range pixel is pushed as {x[8:0], y[7:0], RGB565}.
  - RGB565 = {r[7:3], g[7:2], b[7:3]}.
  - Push when full and no pop in the same cycle: the pixel is dropped, o_overflow set, FIFO unchanged.
  - Push when full with a simultaneous pop: the pixel is accepted and occupancy stays full.
  - Pointers wrap modulo 2^FIFO_DEPTH_LOG2. An occupancy counter of FIFO_DEPTH_LOG2+1 bits distinguishes full from empty.
- Output register:
  - Loads from the FIFO head when (!o_mem_valid || i_mem_ready) and the FIFO is non-empty.
  - On load: o_mem_valid=1, o_mem_addr = (i_fb_base + y*FB_W + x) mod 2^ADDR_W, o_mem_data = packed colour.
  - If the FIFO is empty at that moment and a handshake completes, o_mem_valid falls to 0.
  - o_mem_addr and o_mem_data are held stable while o_mem_valid && !i_mem_ready.
  - A handshake (o_mem_valid && i_mem_ready at the edge) increments o_write_count.
  - Back-to-back handshakes sustain one write per cycle.
- Latency:
  - A pixel sampled at edge t with the FIFO empty and the output idle appears with o_mem_valid=1 after edge t+1.
  - The pixel is not bypassed into the output in the same cycle as its push.
- Ordering: strict input order; no reordering or merging of duplicate addresses.
- o_almost_full is combinational from occupancy.
- i_clear_status:
  - Clears o_overflow, o_clip_count and o_write_count at the next edge.
  - If a set/increment event occurs on the same edge, clear wins, and that event is lost.
  - It does not affect the FIFO or the output register.
- i_fb_base must only change while o_idle=1. Otherwise, addresses of pixels already buffered are undefined.

Test Plan:
- Single pixel (x=5, y=2, r=8'hFF, g=8'h80, b=8'h08), i_fb_base=0, i_mem_ready=1:
  - o_mem_valid is high exactly one cycle, starting after edge t+1, with addr=645 and data=16'hFC01.
  - o_write_count=1 and o_idle=1 afterwards.
- Clipping: pixels at (320,0), (0,240), (-1,10), (319,239):
  - Only (319,239) is written, at addr=76799.
  - o_clip_count=3.
- Backpressure:
  - 16 consecutive pixels with i_mem_ready=0: o_mem_valid holds the first pixel's address/data stable; o_almost_full rises when occupancy reaches 12.
  - Raise ready: all 16 pixels are written in order over 16 consecutive cycles; o_overflow=0.
- Overflow:
  - With i_mem_ready=0, send 20 pixels: 1 sits in the output register, 16 in the FIFO, and 3 are dropped; o_overflow=1.
  - Drain: o_write_count=17.
  - Pulse i_clear_status: all status is 0.
- Full with a simultaneous pop: FIFO full, i_mem_ready=1 and a new pixel in the same cycle:
  - The pixel is accepted and o_overflow stays 0.
- Base wrap and reset mid-transfer:
  - i_fb_base=17'h1FFFF with pixel (1,0) gives addr=0.
  - Assert i_reset_n low while o_mem_valid=1: o_mem_valid drops asynchronously, before the next edge, and all counters read 0.
